spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) clocked by clock50. It is the other end of the SD-card SPI master link.
//  Uses: emulated SD card / loopback target in simulation, or a board-to-board SPI link.
//  Oversamples SCLK/CS/MOSI through synchronizers. Exchanges whole bytes with the local side via a double-buffered
//  TX holding register and a level-valid RX register.
// PARAMETERS
//  DEFAULT_TX   8'hFF  byte shifted out when no TX byte is pending (SD idle line)
//  SYNC_STAGES  2      flops per input synchronizer; legal range >= 2
// PORTS
//  clock50      in   1  system clock, 50 MHz
//  rst_n        in   1  synchronous reset, active-low
//  spi_cs       in   1  chip select from master, active-low
//  spi_sclk     in   1  serial clock from master, idle low
//  spi_mosi     in   1  data from master
//  spi_miso     out  1  data to master; 1 while not selected
//  spi_miso_oe  out  1  1 = drive MISO (synchronized CS low)
//  tx_data      in   8  next byte to send
//  tx_load      in   1  1-cycle strobe: tx_data -> hold register
//  tx_full      out  1  hold register occupied (not yet consumed)
//  rx_data      out  8  last received byte
//  rx_valid     out  1  rx_data unread; held until rx_ack
//  rx_ack       in   1  1-cycle strobe: clears rx_valid and rx_ovr
//  rx_ovr       out  1  sticky: a byte arrived while rx_valid=1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): spi_miso=1, spi_miso_oe=0, tx_full=0, rx_data=0, rx_valid=0, rx_ovr=0.
//   Bit counter=0, state IDLE. Synchronizer chains preset to cs=1, sclk=0, mosi=0.
//   Reset mid-transfer discards partial bytes and the pending TX byte.
//  Edge detect on synchronized signals only: rise/fall = current vs previous synchronized sample.
//   Constraint: SCLK high and low phases >= 4 clock50 cycles each.
//   Edge-to-action latency = SYNC_STAGES+1 cycles.
//  FSM:
//   IDLE   -> ACTIVE on CS fall. Load tx_shift from hold (if tx_full; clear tx_full) else DEFAULT_TX.
//             miso=tx_shift[7], oe=1, cnt=0.
//   ACTIVE, SCLK rise: rx_shift<={rx_shift[6:0],mosi}, cnt<=cnt+1.
//             When cnt==7: rx_data<={rx_shift[6:0],mosi}, rx_valid<=1, cnt<=0.
//             If rx_valid was already 1 and rx_ack is not asserted in the same cycle, set rx_ovr.
//   ACTIVE, SCLK fall: if cnt!=0, shift tx_shift left and set miso=new bit7.
//             If cnt==0 (byte boundary), reload tx_shift as on entry (hold or DEFAULT_TX).
//   ACTIVE -> IDLE on CS rise, at any bit position:
//             partial rx bits dropped, no rx_valid, cnt=0, oe=0, miso=1.
//             A byte already loaded into tx_shift is lost.
//  tx_load: hold<=tx_data, tx_full<=1. A load while tx_full=1 overwrites the hold register silently.
//   Load in the same cycle as a consume: the consume takes the old hold/DEFAULT_TX, the new byte is stored, tx_full=1.
//  rx_ack in the same cycle as a byte completion: the new byte wins, rx_valid stays 1, rx_ovr cleared, not set.
//  SCLK edges while IDLE are ignored. CS fall and SCLK rise in the same cycle: CS handled first, the edge counts as bit 0.
//  Counters: cnt is 3 bits and wraps 7->0 only through the byte-complete path.
// TESTING
//  1. rst_n=0 for 2 cycles with CS low and SCLK toggling -> all outputs at reset values, miso=1, oe=0.
//  2. tx_load 8'h3C, master sends 8'hA5 (8 clocks/bit) -> rx_data=8'hA5, rx_valid=1;
//     master captures 8'h3C; tx_full 1->0 on CS fall.
//  3. No tx_load, master sends 8'h00 -> master reads 8'hFF, rx_data=8'h00.
//  4. Two bytes 8'h11, 8'h22 in one CS frame, no rx_ack -> rx_data=8'h22, rx_valid=1, rx_ovr=1; rx_ack clears both.
//  5. CS raised after 3 SCLK rises of 8'hF0, then full byte 8'h5A -> no rx_valid after abort, then rx_data=8'h5A.
//  6. tx_load 8'h81 coincident with byte-boundary SCLK fall, tx_full=0 -> current byte DEFAULT_TX,
//     next byte 8'h81, tx_full=1 until consumed.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder for the SD-card link, oversampled on clock50.
// Double-buffered TX hold register, level-valid RX register with overrun flag.
module spi_slave #(
  parameter logic [7:0] DEFAULT_TX  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock50,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_ovr
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic cs_q, sclk_q;
  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [7:0] hold;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] next_byte;
  logic [2:0] cnt;

  logic enter, leave, rx_en, tx_step;
  logic consume, shift, byte_done;

  always_ff @(posedge clock50) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  always_ff @(posedge clock50) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // CS edges take priority; a coincident SCLK rise on entry is bit 0
  always_comb begin
    state_n = state;
    enter   = 1'b0;
    leave   = 1'b0;
    rx_en   = 1'b0;
    tx_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = ACTIVE;
          enter   = 1'b1;
          rx_en   = sclk_rise;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n = IDLE;
          leave   = 1'b1;
        end else begin
          rx_en   = sclk_rise;
          tx_step = sclk_fall;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign next_byte = tx_full ? hold : DEFAULT_TX;
  assign consume   = enter | (tx_step & (cnt == 3'd0));
  assign shift     = tx_step & (cnt != 3'd0);
  assign byte_done = rx_en & (cnt == 3'd7);

  always_ff @(posedge clock50) begin
    if (!rst_n) begin
      hold     <= 8'h00;
      tx_full  <= 1'b0;
      tx_shift <= DEFAULT_TX;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      cnt      <= 3'd0;
    end else begin
      if (consume) begin
        tx_shift <= next_byte;
        tx_full  <= 1'b0;
      end else if (shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      // a same-cycle load lands after the consume took the old byte
      if (tx_load) begin
        hold    <= tx_data;
        tx_full <= 1'b1;
      end
      if (leave) begin
        cnt <= 3'd0;
      end else if (rx_en) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        cnt      <= cnt + 3'd1;
      end
      if (byte_done) begin
        rx_data  <= {rx_shift[6:0], mosi_s};
        rx_valid <= 1'b1;
        rx_ovr   <= rx_ack ? 1'b0 : (rx_ovr | rx_valid);
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
        rx_ovr   <= 1'b0;
      end
    end
  end

  assign spi_miso_oe = (state == ACTIVE);
  assign spi_miso    = spi_miso_oe ? tx_shift[7] : 1'b1;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: mode-0 master model, vector table and
// scoreboard queues for received and master-captured bytes.
module tb_spi_slave;

  logic       clock50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_ovr;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mi_q[$];
  logic prv = 1'b0;

  spi_slave #(.DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) dut (
    .clock50(clock50), .rst_n(rst_n),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .rx_ovr(rx_ovr)
  );

  always #5 clock50 = ~clock50;

  typedef struct {
    logic       ld;
    logic [7:0] txb;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock50);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nb,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = mo[7-i];
      cyc(4);
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      cyc(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic byte_ex(input logic [7:0] mo, input string nm);
    logic [7:0] mi;
    xfer(mo, 8, mi);
    if (mi_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected none", nm, mi);
    end else begin
      chk(nm, mi, mi_q.pop_front());
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    cyc(8);
  endtask

  task automatic cs_high();
    cyc(4);
    spi_cs = 1'b1;
    cyc(8);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
    cyc(1);
  endtask

  task automatic load(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  always @(negedge clock50) begin
    if (rst_n && rx_valid && !prv) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected none", rx_data);
      end else begin
        chk("rx_byte", rx_data, rx_q.pop_front());
      end
    end
    prv = rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] dummy;
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{1'b1, 8'hC3, 8'hFF, 8'hC3, 8'hFF};
    vecs[3] = '{1'b1, 8'h00, 8'h96, 8'h00, 8'h96};
    vecs[4] = '{1'b0, 8'h55, 8'h7E, 8'hFF, 8'h7E};

    // reset with a live-looking bus
    cyc(3);
    spi_cs = 1'b0;
    spi_sclk = 1'b1;
    cyc(1);
    spi_sclk = 1'b0;
    cyc(1);
    chk("rst_miso", spi_miso, 1);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_ovr", rx_ovr, 0);
    spi_cs = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(6);

    foreach (vecs[k]) begin
      if (vecs[k].ld) load(vecs[k].txb);
      chk("vec_tx_full_pre", tx_full, vecs[k].ld);
      rx_q.push_back(vecs[k].exp_rx);
      mi_q.push_back(vecs[k].exp_mi);
      cs_low();
      chk("vec_oe", spi_miso_oe, 1);
      chk("vec_tx_full_post", tx_full, 0);
      byte_ex(vecs[k].mo, "vec_miso");
      cs_high();
      chk("vec_rx_valid", rx_valid, 1);
      ack();
      chk("vec_rx_ack", rx_valid, 0);
    end

    // two bytes in one frame, no ack: overrun
    rx_q.push_back(8'h11);
    mi_q.push_back(8'hFF);
    mi_q.push_back(8'hFF);
    cs_low();
    byte_ex(8'h11, "ovr_miso0");
    byte_ex(8'h22, "ovr_miso1");
    cs_high();
    chk("ovr_rx_data", rx_data, 8'h22);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_flag", rx_ovr, 1);
    ack();
    chk("ovr_ack_valid", rx_valid, 0);
    chk("ovr_ack_flag", rx_ovr, 0);

    // abort after three bits, then a full byte
    cs_low();
    xfer(8'hF0, 3, dummy);
    cs_high();
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_oe", spi_miso_oe, 0);
    chk("abort_miso", spi_miso, 1);
    rx_q.push_back(8'h5A);
    mi_q.push_back(8'hFF);
    cs_low();
    byte_ex(8'h5A, "abort_next_miso");
    cs_high();
    chk("abort_next_rx", rx_data, 8'h5A);
    ack();

    // load exactly on the byte-boundary reload cycle
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    rx_q.push_back(8'h03);
    mi_q.push_back(8'hFF);
    mi_q.push_back(8'hFF);
    mi_q.push_back(8'h81);
    cs_low();
    byte_ex(8'h01, "bnd_miso0");
    @(negedge clock50);
    @(negedge clock50);
    tx_data = 8'h81;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    chk("bnd_tx_full0", tx_full, 1);
    ack();
    byte_ex(8'h02, "bnd_miso1");
    chk("bnd_tx_full1", tx_full, 1);
    ack();
    byte_ex(8'h03, "bnd_miso2");
    cyc(4);
    chk("bnd_tx_full2", tx_full, 0);
    ack();
    cs_high();

    chk("rx_q_empty", 8'(rx_q.size()), 8'd0);
    chk("mi_q_empty", 8'(mi_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
